// File: rtl/elevator_controller_param.sv
// Single-car collective (SCAN) elevator controller with configurable floor count,
// per-floor travel time and door dwell time.
module elevator_controller_param #(
    parameter int FLOORS      = 8,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 4,
    localparam int FW         = $clog2(FLOORS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [FW-1:0]     req_floor,
    input  logic              emergency,
    input  logic              over_weight,
    input  logic              IR_sensor,
    output logic              up,
    output logic              down,
    output logic              idle,
    output logic              door,
    output logic              emergency_stop,
    output logic [FW-1:0]     current_floor,
    output logic [FLOORS-1:0] requests,
    output logic [FW-1:0]     min_request,
    output logic [FW-1:0]     max_request
);

    localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR, ST_EMERG} state_t;

    state_t             state, state_n;
    logic               dir_up, dir_up_n;
    logic [FW-1:0]      floor_n;
    logic [FLOORS-1:0]  requests_n;
    logic [MCW-1:0]     move_cnt, move_cnt_n;
    logic [DCW-1:0]     dwell_cnt, dwell_cnt_n;
    logic [FW-1:0]      next_floor;
    logic               has_above, has_below, beyond;
    logic               req_in_range, req_here, latch_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            current_floor <= '0;
            requests      <= '0;
            dir_up        <= 1'b1;
            move_cnt      <= '0;
            dwell_cnt     <= '0;
        end else begin
            state         <= state_n;
            current_floor <= floor_n;
            requests      <= requests_n;
            dir_up        <= dir_up_n;
            move_cnt      <= move_cnt_n;
            dwell_cnt     <= dwell_cnt_n;
        end
    end

    // Pending requests relative to the car now and to the floor it is about to reach
    always_comb begin
        has_above  = 1'b0;
        has_below  = 1'b0;
        beyond     = 1'b0;
        next_floor = current_floor;
        if (dir_up && current_floor != FW'(FLOORS - 1))
            next_floor = current_floor + FW'(1);
        else if (!dir_up && current_floor != '0)
            next_floor = current_floor - FW'(1);
        for (int i = 0; i < FLOORS; i++) begin
            if (requests[i]) begin
                if (i > int'(current_floor)) has_above = 1'b1;
                if (i < int'(current_floor)) has_below = 1'b1;
                if (dir_up ? (i > int'(next_floor)) : (i < int'(next_floor))) beyond = 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        floor_n     = current_floor;
        requests_n  = requests;
        dir_up_n    = dir_up;
        move_cnt_n  = move_cnt;
        dwell_cnt_n = dwell_cnt;

        req_in_range = int'(req_floor) < FLOORS;
        req_here     = req_valid && (req_floor == current_floor);
        latch_ok     = req_valid && req_in_range && !emergency && (state != ST_EMERG)
                       && !((state == ST_DOOR) && req_here);
        if (latch_ok)
            requests_n[req_floor] = 1'b1;

        if (emergency) begin
            state_n     = ST_EMERG;
            move_cnt_n  = '0;
            dwell_cnt_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (requests[current_floor]) begin
                        state_n                    = ST_DOOR;
                        requests_n[current_floor]  = 1'b0;
                        dwell_cnt_n                = '0;
                    end else if (!over_weight) begin
                        if (has_above && (dir_up || !has_below)) begin
                            state_n    = ST_MOVE;
                            dir_up_n   = 1'b1;
                            move_cnt_n = '0;
                        end else if (has_below) begin
                            state_n    = ST_MOVE;
                            dir_up_n   = 1'b0;
                            move_cnt_n = '0;
                        end
                    end
                end
                ST_MOVE: begin
                    if (move_cnt == MCW'(MOVE_CYCLES - 1)) begin
                        move_cnt_n = '0;
                        floor_n    = next_floor;
                        // Arrival clear is applied after the latch so it wins
                        if (requests[next_floor]) begin
                            state_n                 = ST_DOOR;
                            requests_n[next_floor]  = 1'b0;
                            dwell_cnt_n             = '0;
                        end else if (!beyond) begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        move_cnt_n = move_cnt + MCW'(1);
                    end
                end
                ST_DOOR: begin
                    if (IR_sensor || over_weight || req_here) begin
                        dwell_cnt_n = '0;
                    end else if (dwell_cnt == DCW'(DOOR_CYCLES - 1)) begin
                        state_n     = ST_IDLE;
                        dwell_cnt_n = '0;
                    end else begin
                        dwell_cnt_n = dwell_cnt + DCW'(1);
                    end
                end
                default: begin
                    state_n     = ST_IDLE;
                    move_cnt_n  = '0;
                    dwell_cnt_n = '0;
                end
            endcase
        end
    end

    always_comb begin
        min_request = current_floor;
        max_request = current_floor;
        for (int i = FLOORS - 1; i >= 0; i--)
            if (requests[i]) min_request = FW'(i);
        for (int i = 0; i < FLOORS; i++)
            if (requests[i]) max_request = FW'(i);
    end

    assign idle           = (state == ST_IDLE);
    assign up             = (state == ST_MOVE) && dir_up;
    assign down           = (state == ST_MOVE) && !dir_up;
    assign door           = (state == ST_DOOR);
    assign emergency_stop = (state == ST_EMERG);

endmodule

// File: tb/tb_elevator_controller_param.sv
// Bench for elevator_controller_param: an 8-floor and a 6-floor car share stimulus and
// are compared every cycle against a floor-list reference model plus directed checks.
module tb_elevator_controller_param;

    localparam int MOVE_CYCLES = 2;
    localparam int DOOR_CYCLES = 4;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_STOP = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_floor = 3'd0;
    logic       emergency = 1'b0;
    logic       over_weight = 1'b0;
    logic       IR_sensor = 1'b0;

    logic       up_8, down_8, idle_8, door_8, estop_8;
    logic [2:0] floor_8, min_8, max_8;
    logic [7:0] req_8;
    logic       up_6, down_6, idle_6, door_6, estop_6;
    logic [2:0] floor_6, min_6, max_6;
    logic [5:0] req_6;

    int checks = 0;
    int errors = 0;
    int n;
    int prev_door;
    int seen_down;
    int stops[$];

    int         m_mode[2]  = '{M_IDLE, M_IDLE};
    int         m_floor[2] = '{0, 0};
    int         m_dir[2]   = '{1, 1};
    int         m_tl[2]    = '{0, 0};
    int         m_dl[2]    = '{0, 0};
    logic [7:0] m_pend[2]  = '{8'h00, 8'h00};
    int         m_nfl[2]   = '{8, 6};

    elevator_controller_param #(.FLOORS(8), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut8 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .emergency(emergency), .over_weight(over_weight), .IR_sensor(IR_sensor),
        .up(up_8), .down(down_8), .idle(idle_8), .door(door_8), .emergency_stop(estop_8),
        .current_floor(floor_8), .requests(req_8), .min_request(min_8), .max_request(max_8)
    );

    elevator_controller_param #(.FLOORS(6), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut6 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .emergency(emergency), .over_weight(over_weight), .IR_sensor(IR_sensor),
        .up(up_6), .down(down_6), .idle(idle_6), .door(door_6), .emergency_stop(estop_6),
        .current_floor(floor_6), .requests(req_6), .min_request(min_6), .max_request(max_6)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit pending_beyond(input logic [7:0] p, input int f, input int upward);
        for (int i = 0; i < 8; i++)
            if (p[i] && ((upward != 0) ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest(input logic [7:0] p, input int f);
        for (int i = 0; i < 8; i++)
            if (p[i]) return i;
        return f;
    endfunction

    function automatic int highest(input logic [7:0] p, input int f);
        for (int i = 7; i >= 0; i--)
            if (p[i]) return i;
        return f;
    endfunction

    function automatic logic [31:0] exp_flags(input int k);
        logic [4:0] f;
        f = {m_mode[k] == M_MOVE && m_dir[k] == 1, m_mode[k] == M_MOVE && m_dir[k] == 0,
             m_mode[k] == M_IDLE, m_mode[k] == M_DOOR, m_mode[k] == M_STOP};
        return 32'(f);
    endfunction

    task automatic model_reset(input int k);
        m_mode[k]  = M_IDLE;
        m_floor[k] = 0;
        m_dir[k]   = 1;
        m_tl[k]    = 0;
        m_dl[k]    = 0;
        m_pend[k]  = 8'h00;
    endtask

    // Model counts remaining edges until arrival / door close instead of up-counters
    task automatic model_step(input int k);
        logic [7:0] np;
        int         fl;
        int         rf;
        np = m_pend[k];
        fl = m_floor[k];
        rf = int'(req_floor);
        if (req_valid && rf < m_nfl[k] && !emergency && m_mode[k] != M_STOP
            && !(m_mode[k] == M_DOOR && rf == fl))
            np[rf] = 1'b1;
        if (emergency) begin
            m_mode[k] = M_STOP;
        end else begin
            case (m_mode[k])
                M_IDLE: begin
                    if (m_pend[k][fl]) begin
                        m_mode[k] = M_DOOR;
                        np[fl]    = 1'b0;
                        m_dl[k]   = DOOR_CYCLES;
                    end else if (!over_weight) begin
                        if (pending_beyond(m_pend[k], fl, 1)
                            && (m_dir[k] == 1 || !pending_beyond(m_pend[k], fl, 0))) begin
                            m_mode[k] = M_MOVE; m_dir[k] = 1; m_tl[k] = MOVE_CYCLES;
                        end else if (pending_beyond(m_pend[k], fl, 0)) begin
                            m_mode[k] = M_MOVE; m_dir[k] = 0; m_tl[k] = MOVE_CYCLES;
                        end
                    end
                end
                M_MOVE: begin
                    m_tl[k]--;
                    if (m_tl[k] == 0) begin
                        fl = (m_dir[k] == 1) ? fl + 1 : fl - 1;
                        m_floor[k] = fl;
                        if (m_pend[k][fl]) begin
                            m_mode[k] = M_DOOR;
                            np[fl]    = 1'b0;
                            m_dl[k]   = DOOR_CYCLES;
                        end else if (pending_beyond(m_pend[k], fl, m_dir[k])) begin
                            m_tl[k] = MOVE_CYCLES;
                        end else begin
                            m_mode[k] = M_IDLE;
                        end
                    end
                end
                M_DOOR: begin
                    if (IR_sensor || over_weight || (req_valid && rf == fl)) begin
                        m_dl[k] = DOOR_CYCLES;
                    end else begin
                        m_dl[k]--;
                        if (m_dl[k] == 0) m_mode[k] = M_IDLE;
                    end
                end
                default: m_mode[k] = M_IDLE;
            endcase
        end
        m_pend[k] = np;
    endtask

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) model_reset(k);
            else       model_step(k);
        end
    end

    always @(negedge clock) begin
        chk("flags8", {27'b0, up_8, down_8, idle_8, door_8, estop_8}, exp_flags(0));
        chk("floor8", 32'(floor_8), m_floor[0]);
        chk("req8", 32'(req_8), 32'(m_pend[0]));
        chk("min8", 32'(min_8), lowest(m_pend[0], m_floor[0]));
        chk("max8", 32'(max_8), highest(m_pend[0], m_floor[0]));
        chk("flags6", {27'b0, up_6, down_6, idle_6, door_6, estop_6}, exp_flags(1));
        chk("floor6", 32'(floor_6), m_floor[1]);
        chk("req6", 32'(req_6), 32'(m_pend[1]));
        chk("min6", 32'(min_6), lowest(m_pend[1], m_floor[1]));
        chk("max6", 32'(max_6), highest(m_pend[1], m_floor[1]));
    end

    task automatic send_req(input int f);
        req_valid = 1'b1;
        req_floor = 3'(f);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic settle(input int budget);
        int c;
        c = 0;
        while (!(idle_8 && req_8 == 8'h00 && idle_6 && req_6 == 6'h00) && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk("settle_timeout", 32'(c < budget), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_idle", 32'(idle_8), 32'd1);
        chk("rst_motion", 32'({up_8, down_8, door_8, estop_8}), 32'd0);
        chk("rst_floor", 32'(floor_8), 32'd0);
        chk("rst_req", 32'(req_8), 32'd0);
        chk("rst_minmax", 32'({min_8, max_8}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single request to floor 3
        send_req(3);
        chk("s1_latch", 32'(req_8), 32'h08);
        chk("s1_still_idle", 32'(idle_8), 32'd1);
        @(negedge clock);
        chk("s1_up", 32'(up_8), 32'd1);
        n = 0;
        while (!door_8 && n < 40) begin @(negedge clock); n++; end
        chk("s1_travel_cycles", n, 32'd6);
        chk("s1_floor3", 32'(floor_8), 32'd3);
        chk("s1_req_clear", 32'(req_8), 32'd0);
        n = 0;
        while (door_8 && n < 40) begin n++; @(negedge clock); end
        chk("s1_dwell", n, DOOR_CYCLES);
        chk("s1_idle", 32'(idle_8), 32'd1);

        // Collective service: 6, then 4 and 2 picked up while passing 3
        send_req(0);
        settle(100);
        chk("s2_at0", 32'(floor_8), 32'd0);
        send_req(6);
        n = 0;
        while (floor_8 != 3'd3 && n < 40) begin @(negedge clock); n++; end
        send_req(4);
        send_req(2);
        prev_door = 0;
        seen_down = 0;
        n = 0;
        while (!(idle_8 && req_8 == 8'h00) && n < 100) begin
            if (door_8 && prev_door == 0) stops.push_back(int'(floor_8));
            if (down_8 && stops.size() >= 2) seen_down = 1;
            prev_door = int'(door_8);
            @(negedge clock);
            n++;
        end
        chk("s2_nstops", stops.size(), 32'd3);
        if (stops.size() == 3) begin
            chk("s2_stop0", stops[0], 32'd4);
            chk("s2_stop1", stops[1], 32'd6);
            chk("s2_stop2", stops[2], 32'd2);
        end
        chk("s2_reversed", seen_down, 32'd1);
        settle(200);

        // Door held by IR obstruction, then by overweight
        for (int pass = 0; pass < 2; pass++) begin
            send_req(2);
            n = 0;
            while (!door_8 && n < 20) begin @(negedge clock); n++; end
            if (pass == 0) IR_sensor = 1'b1; else over_weight = 1'b1;
            repeat (10) begin
                @(negedge clock);
                chk("s3_door_held", 32'(door_8), 32'd1);
            end
            IR_sensor = 1'b0;
            over_weight = 1'b0;
            n = 1;
            while (n < 20) begin
                @(negedge clock);
                if (!door_8) break;
                n++;
            end
            chk("s3_dwell_after_drop", n, DOOR_CYCLES);
            settle(50);
        end

        // Emergency between floors 2 and 3
        send_req(5);
        n = 0;
        while (!up_8 && n < 20) begin @(negedge clock); n++; end
        emergency = 1'b1;
        @(negedge clock);
        chk("s4_estop", 32'(estop_8), 32'd1);
        chk("s4_motion", 32'({up_8, down_8, door_8}), 32'd0);
        chk("s4_floor", 32'(floor_8), 32'd2);
        chk("s4_req", 32'(req_8), 32'h20);
        send_req(7);
        chk("s4_req7_dropped", 32'(req_8), 32'h20);
        chk("s4_estop_hold", 32'(estop_8), 32'd1);
        @(negedge clock);
        emergency = 1'b0;
        @(negedge clock);
        chk("s4_idle_after", 32'(idle_8), 32'd1);
        @(negedge clock);
        chk("s4_resume_up", 32'(up_8), 32'd1);
        settle(200);

        // Out-of-range floor on the 6-floor car
        send_req(7);
        chk("s5_req6_ignored", 32'(req_6), 32'd0);
        chk("s5_req8_taken", 32'(req_8), 32'h80);
        settle(200);

        // Overweight holds departure from IDLE
        over_weight = 1'b1;
        send_req(4);
        repeat (6) begin
            @(negedge clock);
            chk("s6_hold_idle", 32'(idle_6), 32'd1);
            chk("s6_no_down", 32'(down_6), 32'd0);
            chk("s6_pending", 32'(req_6), 32'h10);
        end
        over_weight = 1'b0;
        @(negedge clock);
        chk("s6_depart", 32'(down_6), 32'd1);
        settle(200);

        // Asynchronous reset mid-move at floor 5
        send_req(7);
        n = 0;
        while (!(floor_8 == 3'd5 && up_8) && n < 40) begin @(negedge clock); n++; end
        chk("s7_at5_moving", 32'({floor_8, up_8}), 32'({3'd5, 1'b1}));
        #2 reset = 1'b1;
        #1;
        chk("s7_floor", 32'(floor_8), 32'd0);
        chk("s7_req", 32'(req_8), 32'd0);
        chk("s7_idle", 32'(idle_8), 32'd1);
        chk("s7_up", 32'(up_8), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Randomised traffic checked cycle by cycle against the model
        for (int c = 0; c < 600; c++) begin
            req_valid   = ($urandom_range(0, 2) == 0);
            req_floor   = 3'($urandom_range(0, 7));
            if (!emergency) emergency = ($urandom_range(0, 39) == 0);
            else            emergency = ($urandom_range(0, 3) != 0);
            IR_sensor   = ($urandom_range(0, 9) == 0);
            over_weight = ($urandom_range(0, 11) == 0);
            @(negedge clock);
        end
        req_valid = 1'b0;
        emergency = 1'b0;
        IR_sensor = 1'b0;
        over_weight = 1'b0;
        settle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_controller_param.md
# elevator_controller_param

Parametrised successor of the 8-floor elevator controller: a single-car collective (SCAN) controller with configurable floor count, per-floor travel time and door dwell time. It latches hall/car requests into a floor bitmap, serves them in the current travel direction before reversing, and holds the door open on IR obstruction or overweight. It also handles emergency stop, and it sits between the request-input logic and the motor/door drive outputs.

## Interface
- FLOORS, 8, number of floors (≥2); floors numbered 0..FLOORS-1
- FW, $clog2(FLOORS), floor index width (derived, localparam)
- MOVE_CYCLES, 2, clock cycles to travel one floor (≥1)
- DOOR_CYCLES, 4, door dwell cycles once unobstructed (≥1)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe, sampled each edge
- req_floor  in  FW  requested floor
- emergency  in  1  emergency stop (level)
- over_weight  in  1  car overweight (level)
- IR_sensor  in  1  door obstruction (level)
- up / down  out  1  motor drive up / down
- idle  out  1  car stationary, door closed, no emergency
- door  out  1  door open
- emergency_stop  out  1  emergency state active
- current_floor  out  FW  car position
- requests  out  FLOORS  pending-request bitmap
- min_request / max_request  out  FW  lowest / highest pending floor

## Operation
- States: IDLE, MOVE, DOOR, EMERG. Moore outputs: idle=IDLE; up=MOVE&dir_up; down=MOVE&!dir_up; door=DOOR; emergency_stop=EMERG.
- Reset values: state IDLE, current_floor 0, requests 0, dir_up 1, counters 0; outputs idle=1, all others 0, min/max_request=0.
- Request latch: on an edge with req_valid=1, set requests[req_floor] unless any of the following holds:
  - req_floor ≥ FLOORS: ignored.
  - emergency=1 or state EMERG: ignored.
  - state DOOR and req_floor==current_floor: not latched; dwell counter restarts.
- IDLE, in priority order:
  - emergency → EMERG.
  - requests[current_floor] → DOOR, clear that bit.
  - over_weight=1 → stay.
  - Request above current_floor and (dir_up or none below) → MOVE, dir_up=1.
  - Any request below → MOVE, dir_up=0.
  - Otherwise stay.
- MOVE: move_cnt counts 0..MOVE_CYCLES-1. On the terminal count, current_floor steps ±1 to nf and move_cnt clears. At that same edge:
  - requests[nf] → DOOR, clear bit; clear wins over a simultaneous new request for nf.
  - Else a request beyond nf in dir → stay MOVE.
  - Else → IDLE (re-evaluates direction).
- DOOR: dwell_cnt counts to DOOR_CYCLES-1 and restarts from 0 on any cycle with IR_sensor=1 or over_weight=1. On the terminal count with both low → IDLE.
- EMERG: all motion stops, door=0, move_cnt and dwell_cnt cleared, current_floor and requests held. emergency=0 → IDLE next edge.
- emergency has priority over every other transition, from any state.
- min/max_request: combinational over requests; equal to current_floor when requests==0.
- current_floor never leaves 0..FLOORS-1; no wrap-around.

## Timing
- Request at edge N is visible on requests after N; IDLE departs at N+1.
- One floor per MOVE_CYCLES cycles; door asserts the same edge the car reaches the target floor.
- Door is high for exactly DOOR_CYCLES cycles after the last obstruction/overweight cycle.
- emergency asserted before edge E: emergency_stop=1 and up=down=0 after E.
- reset asynchronous: outputs take reset values immediately, including mid-move; the first action occurs on the first edge after release.

## Test plan
- FLOORS=8, MOVE_CYCLES=2, DOOR_CYCLES=4:
  - Stimulus: reset, then req 3. Required response: up=1 one edge after latch; current_floor 0→1→2→3 at 2-cycle intervals; door=1 for 4 cycles; requests=0; then idle=1.
  - Stimulus: at floor 0, req 6; while passing floor 3, req 4 and req 2. Required response: stops at 4 then 6, reverses (down=1), stops at 2; requests bit 2 cleared last.
  - Stimulus: IR_sensor high for 10 cycles during DOOR. Required response: door stays 1; door falls 4 cycles after IR_sensor drops. Same check with over_weight.
  - Stimulus: emergency mid-move between floors 2 and 3; req 7 while emergency. Required response: emergency_stop=1, up=0, floor held at 2, requests unchanged, req 7 dropped. After release: idle for one edge, then travel resumes.
- FLOORS=6:
  - Stimulus: req_floor 7. Required response: requests unchanged.
  - Stimulus: over_weight=1 in IDLE with req 4 pending. Required response: no departure until over_weight=0.
- Stimulus: reset asserted mid-MOVE at floor 5. Required response: current_floor=0, requests=0, idle=1 without waiting for a clock edge.
